mem_port_arbiter: RTL and testbench

//  Shares one single-port 64-bit data memory between two requesters: the fetch port (F, read-only) and
//  the memory-stage port (D, read/write), as needed once fetch and memory stages run concurrently.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch F read-only, memory-stage D read/write) in front of one single-port 64-bit memory.
// Optional build macro: MEM_ARB_STARVE_GUARD_EN forces F through after STARVE_LIMIT contested D grants.
module mem_port_arbiter #(
  parameter int MEM_DEPTH    = 1024,
  parameter int AW           = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          f_req,
  input  logic [63:0]   f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [63:0]   f_rdata,
  output logic          f_bad,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [63:0]   d_rdata,
  output logic          d_bad,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [63:0]   m_wdata,
  input  logic [63:0]   m_rdata,
  output logic          busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  localparam logic [63:0] DEPTH_W = 64'(MEM_DEPTH);
  localparam logic        OWN_F   = 1'b0;
  localparam logic        OWN_D   = 1'b1;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   bad_q, bad_d;
  logic   rd_q, rd_d;

  logic   f_in_range_s, d_in_range_s;
  logic   force_f_s;
  logic   grant_f_s, grant_d_s;
  logic   resp_s;

  // Full-width compare: upper address bits must never alias into the array.
  assign f_in_range_s = (f_addr < DEPTH_W);
  assign d_in_range_s = (d_addr < DEPTH_W);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    bad_d     = bad_q;
    rd_d      = rd_q;
    grant_f_s = 1'b0;
    grant_d_s = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = 64'd0;
    case (state_q)
      S_IDLE: begin
        if (reset) begin
          state_d = S_IDLE;
        end else if (d_req && !(f_req && force_f_s)) begin
          grant_d_s = 1'b1;
          state_d   = S_RESP;
          owner_d   = OWN_D;
          bad_d     = !d_in_range_s;
          rd_d      = d_in_range_s && !d_we;
          if (d_in_range_s) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr[AW-1:0];
            m_wdata = d_wdata;
          end else begin
            m_en    = 1'b0;
          end
        end else if (f_req) begin
          grant_f_s = 1'b1;
          state_d   = S_RESP;
          owner_d   = OWN_F;
          bad_d     = !f_in_range_s;
          rd_d      = f_in_range_s;
          if (f_in_range_s) begin
            m_en   = 1'b1;
            m_addr = f_addr[AW-1:0];
          end else begin
            m_en   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_F;
      bad_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bad_q   <= bad_d;
      rd_q    <= rd_d;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int             SCW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
  localparam logic [SCW-1:0] CNT_ONE    = SCW'(1);

  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

  assign force_f_s = (starve_cnt_q == STARVE_MAX);

  // Count D grants that leave a waiting F behind; saturate at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_f_s) begin
      starve_cnt_d = '0;
    end else if (grant_d_s && f_req && !force_f_s) begin
      starve_cnt_d = starve_cnt_q + CNT_ONE;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_f_s = 1'b0;
`endif

  // A reset landing in RESP suppresses the response in that same cycle.
  assign resp_s  = (state_q == S_RESP) && !reset;

  assign f_gnt   = grant_f_s;
  assign d_gnt   = grant_d_s;
  assign busy    = resp_s;

  assign f_valid = resp_s && (owner_q == OWN_F);
  assign d_valid = resp_s && (owner_q == OWN_D);
  assign f_bad   = f_valid && bad_q;
  assign d_bad   = d_valid && bad_q;
  assign f_rdata = (f_valid && rd_q) ? m_rdata : 64'd0;
  assign d_rdata = (d_valid && rd_q) ? m_rdata : 64'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard queue, contention/reset/starvation sequences.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        f_req;
  logic [63:0] f_addr;
  logic        f_gnt, f_valid, f_bad;
  logic [63:0] f_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic        d_gnt, d_valid, d_bad;
  logic [63:0] d_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [63:0] m_wdata, m_rdata;
  logic        busy;

  mem_port_arbiter #(.MEM_DEPTH(1024), .AW(10), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata), .f_bad(f_bad),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_bad(d_bad),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External memory: mem[i] = 0xA000+i except mem[5] = 12; registered read data.
  logic        mem_init;
  logic [63:0] mem [0:1023];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 64'hA000 + 64'(i);
      mem[5] <= 64'd12;
    end else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  typedef struct {
    logic        port;
    logic [63:0] rdata;
    logic        bad;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_bad;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[13];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;
  int          f_gnt_n = 0, d_gnt_n = 0;
  int          f_gnt_cyc = 0, d_gnt_cyc = 0;
  logic        f_gnt_seen, d_gnt_seen;
  logic        hold_reqs = 1'b0;
  logic [63:0] f_exp_rdata, d_exp_rdata;
  logic        f_exp_bad, d_exp_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Compare one settled cycle: pending response if any, otherwise grant/strobe behaviour.
  task automatic monitor();
    exp_t e;
    f_gnt_seen = 1'b0;
    d_gnt_seen = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("busy_resp", 64'(busy), 64'd1);
      chk("gnt_in_resp", 64'({f_gnt, d_gnt}), 64'd0);
      chk("m_en_in_resp", 64'(m_en), 64'd0);
      if (e.port) begin
        chk("d_valid", 64'(d_valid), 64'd1);
        chk("d_rdata", d_rdata, e.rdata);
        chk("d_bad", 64'(d_bad), 64'(e.bad));
        chk("f_valid_other", 64'(f_valid), 64'd0);
        chk("f_rdata_other", f_rdata, 64'd0);
      end else begin
        chk("f_valid", 64'(f_valid), 64'd1);
        chk("f_rdata", f_rdata, e.rdata);
        chk("f_bad", 64'(f_bad), 64'(e.bad));
        chk("d_valid_other", 64'(d_valid), 64'd0);
        chk("d_rdata_other", d_rdata, 64'd0);
      end
    end else begin
      chk("valid_idle", 64'({f_valid, d_valid, f_bad, d_bad}), 64'd0);
      chk("busy_idle", 64'(busy), 64'd0);
      if (d_gnt) begin
        d_gnt_seen = 1'b1;
        d_gnt_n++;
        d_gnt_cyc = cyc_n;
        chk("f_gnt_with_d", 64'(f_gnt), 64'd0);
        chk("d_gnt_req", 64'(d_req), 64'd1);
        chk("d_m_en", 64'(m_en), 64'(!d_exp_bad));
        if (!d_exp_bad) begin
          chk("d_m_we", 64'(m_we), 64'(d_we));
          chk("d_m_addr", 64'(m_addr), 64'(d_addr[9:0]));
          if (d_we) chk("d_m_wdata", m_wdata, d_wdata);
        end
        sb.push_back('{1'b1, d_exp_rdata, d_exp_bad});
      end else if (f_gnt) begin
        f_gnt_seen = 1'b1;
        f_gnt_n++;
        f_gnt_cyc = cyc_n;
        chk("f_gnt_req", 64'(f_req), 64'd1);
        chk("f_m_en", 64'(m_en), 64'(!f_exp_bad));
        chk("f_m_we", 64'(m_we), 64'd0);
        if (!f_exp_bad) chk("f_m_addr", 64'(m_addr), 64'(f_addr[9:0]));
        sb.push_back('{1'b0, f_exp_rdata, f_exp_bad});
      end else begin
        chk("m_en_no_gnt", 64'(m_en), 64'd0);
      end
    end
  endtask

  // One clock: settle, check, advance; a granted requester drops req afterwards.
  task automatic cycle();
    #1;
    monitor();
    @(posedge clock);
    #1;
    cyc_n++;
    if (!hold_reqs) begin
      if (f_gnt_seen) f_req = 1'b0;
      if (d_gnt_seen) d_req = 1'b0;
    end
  endtask

  task automatic run_txn(input vec_t v, output int waited);
    logic got;
    got = 1'b0;
    waited = 0;
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      d_exp_rdata = v.exp_rdata; d_exp_bad = v.exp_bad;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
      f_exp_rdata = v.exp_rdata; f_exp_bad = v.exp_bad;
    end
    for (int k = 0; k < 8 && !got; k++) begin
      cycle();
      if (v.port ? d_gnt_seen : f_gnt_seen) got = 1'b1;
      else waited++;
    end
    chk("gnt_timeout", 64'(got), 64'd1);
    f_req = 1'b0;
    d_req = 1'b0;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int f0, d0, seen_f, d_at_f1, d_at_f2;

    vecs[0]  = '{1'b0, 1'b0, 64'd5,                   64'd0,                  64'd12,                 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 64'd7,                   64'hDEAD,               64'd0,                  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 64'd7,                   64'd0,                  64'hDEAD,               1'b0};
    vecs[3]  = '{1'b0, 1'b0, 64'd7,                   64'd0,                  64'hDEAD,               1'b0};
    vecs[4]  = '{1'b1, 1'b1, 64'd1024,                64'h0BAD,               64'd0,                  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 64'h1_0000_0003,         64'd0,                  64'd0,                  1'b1};
    vecs[6]  = '{1'b1, 1'b0, 64'd3,                   64'd0,                  64'hA003,               1'b0};
    vecs[7]  = '{1'b0, 1'b0, 64'd1023,                64'd0,                  64'hA3FF,               1'b0};
    vecs[8]  = '{1'b1, 1'b0, 64'd1024,                64'd0,                  64'd0,                  1'b1};
    vecs[9]  = '{1'b1, 1'b1, 64'd1023,                64'hFFFF_0000_1234_5678, 64'd0,                 1'b0};
    vecs[10] = '{1'b0, 1'b0, 64'd1023,                64'd0,                  64'hFFFF_0000_1234_5678, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0,                  64'd0,                  1'b1};
    vecs[12] = '{1'b0, 1'b0, 64'd0,                   64'd0,                  64'hA000,               1'b0};

    // Reset with both requests high: nothing may be granted or strobed.
    reset = 1'b1; mem_init = 1'b1;
    f_req = 1'b1; f_addr = 64'd5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd9; d_wdata = 64'd1;
    f_exp_rdata = 64'd0; f_exp_bad = 1'b0; d_exp_rdata = 64'd0; d_exp_bad = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("rst_gnt", 64'({f_gnt, d_gnt}), 64'd0);
      chk("rst_m", 64'({m_en, m_we}), 64'd0);
      chk("rst_valid", 64'({f_valid, d_valid, f_bad, d_bad, busy}), 64'd0);
      chk("rst_rdata", f_rdata | d_rdata, 64'd0);
    end
    f_req = 1'b0; d_req = 1'b0; reset = 1'b0; mem_init = 1'b0;
    cycle();

    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i], waited);
      chk("gnt_latency", 64'(waited), 64'd0);
    end

    // Contention: D first, F on the next IDLE cycle.
    f_req = 1'b1; f_addr = 64'd5; f_exp_rdata = 64'd12; f_exp_bad = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd3; d_exp_rdata = 64'hA003; d_exp_bad = 1'b0;
    for (int k = 0; k < 8 && (f_req || d_req); k++) cycle();
    chk("contend_both_done", 64'({f_req, d_req}), 64'd0);
    cycle();
    chk("contend_gap", 64'(f_gnt_cyc - d_gnt_cyc), 64'd2);

    // Reset during the RESP cycle of a D read aborts the response.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd7; d_exp_rdata = 64'hDEAD; d_exp_bad = 1'b0;
    cycle();
    chk("rst_resp_granted", 64'(d_gnt_seen), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_resp_d_valid", 64'(d_valid), 64'd0);
    chk("rst_resp_busy", 64'(busy), 64'd0);
    chk("rst_resp_d_rdata", d_rdata, 64'd0);
    sb.delete();
    @(posedge clock);
    #1;
    cyc_n++;
    reset = 1'b0;
    #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_valid", 64'({f_valid, d_valid}), 64'd0);
    @(posedge clock);
    #1;
    cyc_n++;
    run_txn(vecs[2], waited);
    chk("post_rst_latency", 64'(waited), 64'd0);

    // Saturated D with F waiting.
    hold_reqs = 1'b1;
    f_req = 1'b1; f_addr = 64'd5; f_exp_rdata = 64'd12; f_exp_bad = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd3; d_exp_rdata = 64'hA003; d_exp_bad = 1'b0;
    f0 = f_gnt_n; d0 = d_gnt_n; seen_f = 0; d_at_f1 = -1; d_at_f2 = -1;
    for (int k = 0; k < 22; k++) begin
      cycle();
      if (f_gnt_seen) begin
        if (seen_f == 0) d_at_f1 = d_gnt_n - d0;
        else if (seen_f == 1) d_at_f2 = d_gnt_n - d0;
        seen_f++;
      end
    end
    hold_reqs = 1'b0;
    f_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_first_f", 64'(d_at_f1), 64'd4);
    chk("starve_cnt_cleared", 64'(d_at_f2 - d_at_f1), 64'd4);
    chk("starve_f_count", 64'(f_gnt_n - f0), 64'd2);
`else
    chk("starve_f_never", 64'(f_gnt_n - f0), 64'd0);
    chk("starve_d_count", 64'(d_gnt_n - d0), 64'd11);
`endif
    cycle();
    cycle();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
